// File: rtl/prng_sample_packer.sv
// Purpose: packs PACK consecutive N-bit PRNG samples into one wide word,
// buffers packed words in a show-ahead FIFO with a valid/ready output, and
// runs a repetition-count health test that flags a stuck generator.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   sample_in/valid       PRNG output word and its done strobe (no backpressure)
//   word_out/valid/ready  FIFO head (first sample in LSBs), non-empty, pop
//   fifo_count            words currently buffered
//   overflow              sticky: a packed word was dropped on a full FIFO
//   stuck_alarm           sticky: REP_LIMIT identical samples in a row
//   clear_alarms          clears both sticky alarms (a set in the same cycle wins)
module prng_sample_packer #(
    parameter int unsigned N         = 4,
    parameter int unsigned PACK      = 4,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned REP_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N-1:0]                 sample_in,
    input  logic                         sample_valid,
    output logic [N*PACK-1:0]            word_out,
    output logic                         word_valid,
    input  logic                         word_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         overflow,
    output logic                         stuck_alarm,
    input  logic                         clear_alarms
);

    localparam int unsigned W     = N * PACK;
    localparam int unsigned IDX_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned RUN_W = $clog2(REP_LIMIT + 1);

    logic [IDX_W-1:0] pack_idx;
    logic [W-1:0]     partial;
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [N-1:0]     prev;
    logic             have_prev;
    logic [RUN_W-1:0] run;

    logic [W-1:0]     packed_c;
    logic [W-1:0]     head_c;
    logic [PTR_W-1:0] rd_next_c;
    logic [RUN_W-1:0] run_next_c;
    logic             last_c;
    logic             pop_c;
    logic             full_c;
    logic             wr_en_c;
    logic             drop_c;
    logic             trip_c;

    // Completed word: stored slots plus the sample arriving in the top slot.
    always_comb begin
        packed_c          = partial;
        packed_c[W-N +: N] = sample_in;
    end

    assign last_c    = sample_valid && (pack_idx == IDX_W'(PACK - 1));
    assign pop_c     = word_valid && word_ready;
    assign full_c    = (fifo_count == CNT_W'(DEPTH));
    assign wr_en_c   = last_c && (!full_c || pop_c);
    assign drop_c    = last_c && full_c && !pop_c;
    assign rd_next_c = rd_ptr + PTR_W'(1);

    // Run length saturates at REP_LIMIT so the alarm condition stays true.
    always_comb begin
        run_next_c = RUN_W'(1);
        if (have_prev && (sample_in == prev)) begin
            run_next_c = (run == RUN_W'(REP_LIMIT)) ? run : run + RUN_W'(1);
        end
    end

    assign trip_c = sample_valid && (run_next_c == RUN_W'(REP_LIMIT));

    // Next show-ahead head; holds the last value once the FIFO drains.
    always_comb begin
        head_c = word_out;
        if (pop_c) begin
            if (fifo_count == CNT_W'(1)) begin
                if (wr_en_c) begin
                    head_c = packed_c;
                end
            end else begin
                head_c = mem[rd_next_c];
            end
        end else if (wr_en_c && (fifo_count == '0)) begin
            head_c = packed_c;
        end
    end

    // Packing and repetition-test state.
    always_ff @(posedge clk) begin
        if (reset) begin
            pack_idx  <= '0;
            partial   <= '0;
            prev      <= '0;
            have_prev <= 1'b0;
            run       <= '0;
        end else if (sample_valid) begin
            for (int unsigned k = 0; k < PACK; k++) begin
                if (pack_idx == IDX_W'(k)) begin
                    partial[k*N +: N] <= sample_in;
                end
            end
            pack_idx  <= last_c ? '0 : pack_idx + IDX_W'(1);
            prev      <= sample_in;
            have_prev <= 1'b1;
            run       <= run_next_c;
        end
    end

    // FIFO storage; contents are meaningless after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (!reset && wr_en_c) begin
            mem[wr_ptr] <= packed_c;
        end
    end

    // FIFO pointers, count and registered head.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            word_valid <= 1'b0;
            word_out   <= '0;
        end else begin
            if (wr_en_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_next_c;
            end
            if (wr_en_c && !pop_c) begin
                fifo_count <= fifo_count + CNT_W'(1);
                word_valid <= 1'b1;
            end else if (!wr_en_c && pop_c) begin
                fifo_count <= fifo_count - CNT_W'(1);
                word_valid <= (fifo_count != CNT_W'(1));
            end
            word_out <= head_c;
        end
    end

    // Sticky alarms; a set condition beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow    <= 1'b0;
            stuck_alarm <= 1'b0;
        end else begin
            if (drop_c) begin
                overflow <= 1'b1;
            end else if (clear_alarms) begin
                overflow <= 1'b0;
            end
            if (trip_c) begin
                stuck_alarm <= 1'b1;
            end else if (clear_alarms) begin
                stuck_alarm <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prng_sample_packer.sv
// Directed bench for prng_sample_packer with N=4, PACK=4, DEPTH=4, REP_LIMIT=8.
module tb_prng_sample_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  sample_in;
    logic        sample_valid;
    logic [15:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic        stuck_alarm;
    logic        clear_alarms;

    int total = 0;
    int bad   = 0;

    prng_sample_packer #(.N(4), .PACK(4), .DEPTH(4), .REP_LIMIT(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .stuck_alarm  (stuck_alarm),
        .clear_alarms (clear_alarms)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it in, then settle past the edge.
    task automatic step(input logic rst, input logic v, input logic [3:0] s,
                        input logic rdy, input logic clr);
        reset        = rst;
        sample_valid = v;
        sample_in    = s;
        word_ready   = rdy;
        clear_alarms = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic smp(input logic [3:0] s);
        step(1'b0, 1'b1, s, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic rdy, input logic clr);
        step(1'b0, 1'b0, 4'h0, rdy, clr);
    endtask

    initial begin
        reset = 1'b1; sample_valid = 1'b0; sample_in = '0;
        word_ready = 1'b0; clear_alarms = 1'b0;
        #1;

        // 1. reset state and first word latency
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        chk("rst_valid", 32'(word_valid), 32'h0);
        chk("rst_word", 32'(word_out), 32'h0);
        chk("rst_count", 32'(fifo_count), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_stuck", 32'(stuck_alarm), 32'h0);
        smp(4'h1); smp(4'h2); smp(4'h3);
        chk("t1_valid_early", 32'(word_valid), 32'h0);
        smp(4'h4);
        chk("t1_valid", 32'(word_valid), 32'h1);
        chk("t1_word", 32'(word_out), 32'h4321);
        chk("t1_count", 32'(fifo_count), 32'h1);

        // 2. five words into a 4-deep FIFO
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        for (int i = 1; i <= 16; i++) smp(4'(i));  // 1..F then 0
        chk("t2_count4", 32'(fifo_count), 32'h4);
        chk("t2_no_ovf_yet", 32'(overflow), 32'h0);
        smp(4'h2); smp(4'h3); smp(4'h4); smp(4'h5);
        chk("t2_ovf", 32'(overflow), 32'h1);
        chk("t2_count_full", 32'(fifo_count), 32'h4);
        chk("t2_head_kept", 32'(word_out), 32'h4321);
        idle(1'b0, 1'b1);
        chk("t2_ovf_cleared", 32'(overflow), 32'h0);
        chk("t2_count_after_clr", 32'(fifo_count), 32'h4);

        // 3. push and pop together while full
        smp(4'h6); smp(4'h7); smp(4'h8);
        step(1'b0, 1'b1, 4'h9, 1'b1, 1'b0);
        chk("t3_no_ovf", 32'(overflow), 32'h0);
        chk("t3_count", 32'(fifo_count), 32'h4);
        chk("t3_head", 32'(word_out), 32'h8765);
        idle(1'b1, 1'b0);
        chk("t3_pop1", 32'(word_out), 32'hCBA9);
        idle(1'b1, 1'b0);
        chk("t3_pop2", 32'(word_out), 32'h0FED);
        idle(1'b1, 1'b0);
        chk("t3_pop3", 32'(word_out), 32'h9876);
        chk("t3_count1", 32'(fifo_count), 32'h1);
        idle(1'b1, 1'b0);
        chk("t3_empty_valid", 32'(word_valid), 32'h0);
        chk("t3_empty_hold", 32'(word_out), 32'h9876);
        idle(1'b1, 1'b0);
        chk("t3_ready_empty", 32'(fifo_count), 32'h0);

        // 4. eight identical samples trip the alarm on the 8th edge
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) smp(4'hA);
        chk("t4_not_7th", 32'(stuck_alarm), 32'h0);
        smp(4'hA);
        chk("t4_8th", 32'(stuck_alarm), 32'h1);
        chk("t4_count", 32'(fifo_count), 32'h2);
        chk("t4_word", 32'(word_out), 32'hAAAA);
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) smp(4'hA);
        smp(4'h5);
        chk("t4_seven_then_5", 32'(stuck_alarm), 32'h0);

        // 6. clear coinciding with a saturated run: set wins
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) smp(4'hA);
        step(1'b0, 1'b1, 4'hA, 1'b0, 1'b1);
        chk("t6_set_wins", 32'(stuck_alarm), 32'h1);
        idle(1'b0, 1'b1);
        chk("t6_clear", 32'(stuck_alarm), 32'h0);
        chk("t6_fifo_kept", 32'(fifo_count), 32'h2);

        // 5. mid-word reset discards the partial word
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) smp(4'h3);
        chk("t5_alarm_before", 32'(stuck_alarm), 32'h1);
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        smp(4'h1); smp(4'h2);
        step(1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
        smp(4'h7); smp(4'h8); smp(4'h9); smp(4'hA);
        chk("t5_word", 32'(word_out), 32'hA987);
        chk("t5_count", 32'(fifo_count), 32'h1);
        chk("t5_stuck", 32'(stuck_alarm), 32'h0);
        chk("t5_ovf", 32'(overflow), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
